// File: rtl/data_cache_pkg.sv
// Shared types for the 2-way write-back data cache: controller states, store write ops,
// default geometry and the victim-selection rule.
package data_cache_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_INDEX_BITS = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAG_CHECK,
        ST_WRITEBACK,
        ST_REFILL,
        ST_FLUSH_SCAN,
        ST_FLUSH_WB
    } state_t;

    // Single write port of the line store; each op touches one (set, way) entry.
    typedef enum logic [2:0] {
        WR_NONE,
        WR_TOUCH,
        WR_MERGE,
        WR_INSTALL,
        WR_CLEAN
    } wr_op_t;

    // First invalid way wins (way0 before way1); with both valid, LRU decides.
    function automatic logic pick_victim(input logic [1:0] way_valid, input logic lru);
        if (!way_valid[0]) return 1'b0;
        if (!way_valid[1]) return 1'b1;
        return lru;
    endfunction

endpackage

// File: rtl/data_cache_line_store.sv
// Two-way line arrays: tag/data without reset, valid/dirty/LRU cleared asynchronously.
// Combinational read of both ways by index, one write port selected by wr_op.
module data_cache_line_store
    import data_cache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_ADDR_WIDTH - DEF_INDEX_BITS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INDEX_BITS-1:0]         rd_index,
    output logic [1:0]                    rd_valid,
    output logic [1:0][TAG_BITS-1:0]      rd_tag,
    output logic [1:0][DATA_WIDTH-1:0]    rd_data,
    output logic [1:0][DATA_WIDTH/8-1:0]  rd_dirty,
    output logic                          rd_lru,
    input  wr_op_t                        wr_op,
    input  logic [INDEX_BITS-1:0]         wr_index,
    input  logic                          wr_way,
    input  logic [TAG_BITS-1:0]           wr_tag,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [DATA_WIDTH/8-1:0]       wr_mask
);

    localparam int SETS  = 2 ** INDEX_BITS;
    localparam int BYTES = DATA_WIDTH / 8;

    logic [1:0]                 valid_q [SETS];
    logic [1:0][BYTES-1:0]      dirty_q [SETS];
    logic [SETS-1:0]            lru_q;
    logic [1:0][TAG_BITS-1:0]   tag_q   [SETS];
    logic [1:0][DATA_WIDTH-1:0] data_q  [SETS];

    logic                  valid_we, dirty_we, lru_we, tag_we, data_we;
    logic                  valid_d, lru_d;
    logic [BYTES-1:0]      dirty_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] cur_data, merged;
    logic [BYTES-1:0]      cur_dirty;

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_lru   = lru_q[rd_index];

    always_comb begin
        cur_data  = data_q[wr_index][wr_way];
        cur_dirty = dirty_q[wr_index][wr_way];
        merged    = cur_data;
        for (int b = 0; b < BYTES; b++) begin
            if (wr_mask[b]) merged[b*8 +: 8] = wr_data[b*8 +: 8];
        end
    end

    always_comb begin
        valid_we = 1'b0;
        dirty_we = 1'b0;
        lru_we   = 1'b0;
        tag_we   = 1'b0;
        data_we  = 1'b0;
        valid_d  = 1'b0;
        lru_d    = ~wr_way;
        dirty_d  = '0;
        data_d   = wr_data;
        case (wr_op)
            WR_TOUCH: lru_we = 1'b1;
            WR_MERGE: begin
                lru_we   = 1'b1;
                data_we  = 1'b1;
                data_d   = merged;
                dirty_we = 1'b1;
                dirty_d  = cur_dirty | wr_mask;
            end
            WR_INSTALL: begin
                valid_we = 1'b1;
                valid_d  = 1'b1;
                tag_we   = 1'b1;
                data_we  = 1'b1;
                dirty_we = 1'b1;
            end
            WR_CLEAN: dirty_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (valid_we) valid_q[wr_index][wr_way] <= valid_d;
            if (dirty_we) dirty_q[wr_index][wr_way] <= dirty_d;
            if (lru_we)   lru_q[wr_index]           <= lru_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we)  tag_q[wr_index][wr_way]  <= wr_tag;
        if (data_we) data_q[wr_index][wr_way] <= data_d;
    end

endmodule

// File: rtl/data_cache_wb.sv
// 2-way set-associative write-back data cache with write-allocate refill,
// byte-granular dirty writeback and a whole-cache flush walk.
//
// state          | meaning
// ST_IDLE        | ready for a request; flush_all has priority
// ST_TAG_CHECK   | compare tags, respond on hit, pick victim on miss
// ST_WRITEBACK   | write dirty victim bytes to memory
// ST_REFILL      | read requested word from memory and install it
// ST_FLUSH_SCAN  | visit one (set, way) entry per cycle
// ST_FLUSH_WB    | write back a dirty entry found by the scan
module data_cache_wb
    import data_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_mask,
    output logic                    req_ready,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    flush_all,
    output logic                    flush_done,
    output logic                    mem_req_valid,
    output logic                    mem_req_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    output logic [DATA_WIDTH/8-1:0] mem_write_mask,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_read_data
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS;
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int CNT_BITS = INDEX_BITS + 1;

    state_t                state_q, state_d;
    logic                  req_write_q, req_write_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
    logic [BYTES-1:0]      req_mask_q, req_mask_d;
    logic                  victim_q, victim_d;
    logic [CNT_BITS-1:0]   flush_cnt_q, flush_cnt_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

    logic [1:0]                 rd_valid;
    logic [1:0][TAG_BITS-1:0]   rd_tag;
    logic [1:0][DATA_WIDTH-1:0] rd_data;
    logic [1:0][BYTES-1:0]      rd_dirty;
    logic                       rd_lru;
    logic [INDEX_BITS-1:0]      rd_index;

    wr_op_t                wr_op;
    logic [INDEX_BITS-1:0] wr_index;
    logic                  wr_way;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BYTES-1:0]      wr_mask;

    logic [INDEX_BITS-1:0] req_index, fl_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  fl_way, fl_last, fl_dirty_entry;
    logic [1:0]            hit_vec;
    logic                  hit, hit_way, victim_sel, flushing;

    assign req_index = req_addr_q[INDEX_BITS-1:0];
    assign req_tag   = req_addr_q[ADDR_WIDTH-1:INDEX_BITS];
    // Flush counter walks {set, way}: both ways of a set on consecutive cycles.
    assign fl_index  = flush_cnt_q[CNT_BITS-1:1];
    assign fl_way    = flush_cnt_q[0];
    assign fl_last   = (flush_cnt_q == {CNT_BITS{1'b1}});
    assign flushing  = (state_q == ST_FLUSH_SCAN) || (state_q == ST_FLUSH_WB);
    assign rd_index  = flushing ? fl_index : req_index;

    assign hit_vec[0]     = rd_valid[0] && (rd_tag[0] == req_tag);
    assign hit_vec[1]     = rd_valid[1] && (rd_tag[1] == req_tag);
    assign hit            = |hit_vec;
    assign hit_way        = hit_vec[1];
    assign victim_sel     = pick_victim(rd_valid, rd_lru);
    assign fl_dirty_entry = rd_valid[fl_way] && (|rd_dirty[fl_way]);

    data_cache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_store (
        .clk      (clk),
        .reset    (reset),
        .rd_index (rd_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .rd_dirty (rd_dirty),
        .rd_lru   (rd_lru),
        .wr_op    (wr_op),
        .wr_index (wr_index),
        .wr_way   (wr_way),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_mask_q  <= '0;
            victim_q    <= 1'b0;
            flush_cnt_q <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_mask_q  <= req_mask_d;
            victim_q    <= victim_d;
            flush_cnt_q <= flush_cnt_d;
            read_data_q <= read_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_mask_d  = req_mask_q;
        victim_d    = victim_q;
        flush_cnt_d = flush_cnt_q;
        read_data_d = read_data_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_all) begin
                    state_d     = ST_FLUSH_SCAN;
                    flush_cnt_d = '0;
                end else if (req_valid) begin
                    state_d     = ST_TAG_CHECK;
                    req_write_d = req_write;
                    req_addr_d  = address;
                    req_data_d  = write_data;
                    req_mask_d  = write_mask;
                end
            end
            ST_TAG_CHECK: begin
                if (hit) begin
                    if (!req_write_q) read_data_d = rd_data[hit_way];
                    state_d = ST_IDLE;
                end else begin
                    victim_d = victim_sel;
                    state_d  = (rd_valid[victim_sel] && (|rd_dirty[victim_sel]))
                               ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: if (mem_ack) state_d = ST_REFILL;
            ST_REFILL:    if (mem_ack) state_d = ST_TAG_CHECK;
            ST_FLUSH_SCAN: begin
                if (fl_dirty_entry) begin
                    state_d = ST_FLUSH_WB;
                end else if (fl_last) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_FLUSH_WB: begin
                if (mem_ack) begin
                    if (fl_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_FLUSH_SCAN;
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        flush_done     = 1'b0;
        read_data      = read_data_q;
        mem_req_valid  = 1'b0;
        mem_req_write  = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write_mask = '0;
        wr_op          = WR_NONE;
        wr_index       = req_index;
        wr_way         = victim_q;
        wr_tag         = req_tag;
        wr_data        = req_data_q;
        wr_mask        = req_mask_q;
        case (state_q)
            ST_IDLE: req_ready = !flush_all;
            ST_TAG_CHECK: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    wr_way     = hit_way;
                    wr_op      = req_write_q ? WR_MERGE : WR_TOUCH;
                    if (!req_write_q) read_data = rd_data[hit_way];
                end
            end
            ST_WRITEBACK: begin
                mem_req_valid  = 1'b1;
                mem_req_write  = 1'b1;
                mem_address    = {rd_tag[victim_q], req_index};
                mem_write_data = rd_data[victim_q];
                mem_write_mask = rd_dirty[victim_q];
            end
            ST_REFILL: begin
                mem_req_valid = 1'b1;
                mem_address   = req_addr_q;
                if (mem_ack) begin
                    wr_op   = WR_INSTALL;
                    wr_data = mem_read_data;
                end
            end
            ST_FLUSH_SCAN: flush_done = fl_last && !fl_dirty_entry;
            ST_FLUSH_WB: begin
                mem_req_valid  = 1'b1;
                mem_req_write  = 1'b1;
                mem_address    = {rd_tag[fl_way], fl_index};
                mem_write_data = rd_data[fl_way];
                mem_write_mask = rd_dirty[fl_way];
                flush_done     = mem_ack && fl_last;
                wr_index       = fl_index;
                wr_way         = fl_way;
                if (mem_ack) wr_op = WR_CLEAN;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_cache_wb.sv
// Directed bench for data_cache_wb: miss/refill, way fill, store merge, dirty eviction,
// flush walk and reset during a memory transaction.
module tb_data_cache_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [9:0]  address;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic        req_ready, resp_valid;
    logic [31:0] read_data;
    logic        flush_all, flush_done;
    logic        mem_req_valid, mem_req_write;
    logic [9:0]  mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_mask;
    logic        mem_ack;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    logic        log_w [4];
    logic [9:0]  log_a [4];
    logic [31:0] log_d [4];
    logic [3:0]  log_m [4];
    int          n_txn;
    int          resp_lat;
    logic [31:0] resp_data;
    logic        got_resp;

    always #5 clk = ~clk;

    data_cache_wb dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .address        (address),
        .write_data     (write_data),
        .write_mask     (write_mask),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .read_data      (read_data),
        .flush_all      (flush_all),
        .flush_done     (flush_done),
        .mem_req_valid  (mem_req_valid),
        .mem_req_write  (mem_req_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write_mask (mem_write_mask),
        .mem_ack        (mem_ack),
        .mem_read_data  (mem_read_data)
    );

    task automatic log_txn();
        if (n_txn < 4) begin
            log_w[n_txn] = mem_req_write;
            log_a[n_txn] = mem_address;
            log_d[n_txn] = mem_write_data;
            log_m[n_txn] = mem_write_mask;
        end
        n_txn++;
    endtask

    // Issue one request; memory acks after ack_lat waiting cycles, returning rdata.
    task automatic run_req(input logic w, input logic [9:0] a, input logic [31:0] d,
                           input logic [3:0] m, input int ack_lat, input logic [31:0] rdata);
        int wait_cnt;
        n_txn = 0; got_resp = 1'b0; resp_lat = 0; resp_data = '0; wait_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; address = a; write_data = d; write_mask = m;
        for (int cyc = 1; cyc <= 60 && !got_resp; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0; mem_ack = 1'b0;
            #1;
            if (resp_valid) begin
                got_resp = 1'b1; resp_lat = cyc; resp_data = read_data;
            end else if (mem_req_valid) begin
                if (wait_cnt >= ack_lat) begin
                    mem_ack = 1'b1; mem_read_data = rdata; wait_cnt = 0;
                    log_txn();
                end else begin
                    wait_cnt++;
                end
            end
        end
        mem_ack = 1'b0;
    endtask

    // Pulse flush_all; memory acks every write in its issue cycle.
    task automatic run_flush(output logic ready_at_flush, output int done_cnt, output int done_cyc);
        n_txn = 0; done_cnt = 0; done_cyc = 0;
        @(negedge clk);
        flush_all = 1'b1; req_valid = 1'b1; req_write = 1'b0; address = 10'h3FF;
        #1;
        ready_at_flush = req_ready;
        for (int cyc = 2; cyc <= 200; cyc++) begin
            @(negedge clk);
            flush_all = 1'b0; req_valid = 1'b0; mem_ack = 1'b0;
            #1;
            if (mem_req_valid) begin
                mem_ack = 1'b1;
                log_txn();
            end
            #1;
            if (flush_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && cyc >= done_cyc + 4) break;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; address = '0; write_data = '0;
        write_mask = '0; flush_all = 1'b0; mem_ack = 1'b0; mem_read_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got %b want 0", mem_req_valid); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b want 0", flush_done); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h want 0", read_data); end
    endtask

    task automatic test_refill_hit();
        run_req(1'b0, 10'h015, 32'h0, 4'h0, 2, 32'hDEADBEEF);
        checks++; if (!got_resp) begin errors++; $display("FAIL t1_resp_timeout got none want resp"); end
        checks++; if (n_txn !== 1) begin errors++; $display("FAIL t1_txn_count got %0d want 1", n_txn); end
        checks++; if ({log_w[0], log_a[0]} !== {1'b0, 10'h015}) begin errors++; $display("FAIL t1_refill_req got w=%b a=%h want w=0 a=015", log_w[0], log_a[0]); end
        checks++; if (resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_resp_data got %h want DEADBEEF", resp_data); end
        run_req(1'b0, 10'h015, 32'h0, 4'h0, 0, 32'h0);
        checks++; if (n_txn !== 0) begin errors++; $display("FAIL t1_hit_txn got %0d want 0", n_txn); end
        checks++; if (resp_lat !== 1) begin errors++; $display("FAIL t1_hit_latency got %0d want 1", resp_lat); end
        checks++; if (resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_hit_data got %h want DEADBEEF", resp_data); end
    endtask

    task automatic test_second_way();
        run_req(1'b0, 10'h035, 32'h0, 4'h0, 0, 32'hCAFEBABE);
        checks++; if (n_txn !== 1 || log_a[0] !== 10'h035 || log_w[0] !== 1'b0) begin errors++; $display("FAIL t2_refill got n=%0d a=%h w=%b want n=1 a=035 w=0", n_txn, log_a[0], log_w[0]); end
        checks++; if (resp_data !== 32'hCAFEBABE) begin errors++; $display("FAIL t2_resp_data got %h want CAFEBABE", resp_data); end
        run_req(1'b0, 10'h015, 32'h0, 4'h0, 0, 32'h0);
        checks++; if (n_txn !== 0 || resp_lat !== 1 || resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL t2_hit_015 got n=%0d lat=%0d d=%h want n=0 lat=1 d=DEADBEEF", n_txn, resp_lat, resp_data); end
        run_req(1'b0, 10'h035, 32'h0, 4'h0, 0, 32'h0);
        checks++; if (n_txn !== 0 || resp_lat !== 1 || resp_data !== 32'hCAFEBABE) begin errors++; $display("FAIL t2_hit_035 got n=%0d lat=%0d d=%h want n=0 lat=1 d=CAFEBABE", n_txn, resp_lat, resp_data); end
    endtask

    task automatic test_store_hit();
        run_req(1'b1, 10'h015, 32'h12345678, 4'b1000, 0, 32'h0);
        checks++; if (n_txn !== 0 || resp_lat !== 1) begin errors++; $display("FAIL t3_store_hit got n=%0d lat=%0d want n=0 lat=1", n_txn, resp_lat); end
        run_req(1'b0, 10'h015, 32'h0, 4'h0, 0, 32'h0);
        checks++; if (resp_data !== 32'h12ADBEEF) begin errors++; $display("FAIL t3_merged got %h want 12ADBEEF", resp_data); end
        run_req(1'b1, 10'h035, 32'hFFFFFFFF, 4'b0000, 0, 32'h0);
        checks++; if (n_txn !== 0 || resp_lat !== 1) begin errors++; $display("FAIL t3_mask0_store got n=%0d lat=%0d want n=0 lat=1", n_txn, resp_lat); end
        run_req(1'b0, 10'h035, 32'h0, 4'h0, 0, 32'h0);
        checks++; if (n_txn !== 0 || resp_data !== 32'hCAFEBABE) begin errors++; $display("FAIL t3_mask0_data got n=%0d d=%h want n=0 d=CAFEBABE", n_txn, resp_data); end
    endtask

    task automatic test_writeback();
        run_req(1'b1, 10'h055, 32'h19721121, 4'b0011, 1, 32'h0);
        checks++; if (!got_resp || n_txn !== 2) begin errors++; $display("FAIL t4_txn_count got resp=%b n=%0d want resp=1 n=2", got_resp, n_txn); end
        checks++; if ({log_w[0], log_a[0], log_d[0], log_m[0]} !== {1'b1, 10'h015, 32'h12ADBEEF, 4'b1000}) begin errors++; $display("FAIL t4_writeback got w=%b a=%h d=%h m=%b want w=1 a=015 d=12ADBEEF m=1000", log_w[0], log_a[0], log_d[0], log_m[0]); end
        checks++; if ({log_w[1], log_a[1]} !== {1'b0, 10'h055}) begin errors++; $display("FAIL t4_refill got w=%b a=%h want w=0 a=055", log_w[1], log_a[1]); end
        run_req(1'b0, 10'h055, 32'h0, 4'h0, 0, 32'h0);
        checks++; if (n_txn !== 0 || resp_lat !== 1 || resp_data !== 32'h00001121) begin errors++; $display("FAIL t4_load got n=%0d lat=%0d d=%h want n=0 lat=1 d=00001121", n_txn, resp_lat, resp_data); end
    endtask

    task automatic test_flush();
        logic rdy;
        int   done_cnt, done_cyc;
        run_flush(rdy, done_cnt, done_cyc);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL t5_ready_during_flush got %b want 0", rdy); end
        checks++; if (n_txn !== 1) begin errors++; $display("FAIL t5_write_count got %0d want 1", n_txn); end
        checks++; if ({log_w[0], log_a[0], log_d[0], log_m[0]} !== {1'b1, 10'h055, 32'h00001121, 4'b0011}) begin errors++; $display("FAIL t5_flush_write got w=%b a=%h d=%h m=%b want w=1 a=055 d=00001121 m=0011", log_w[0], log_a[0], log_d[0], log_m[0]); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t5_done_pulses got %0d want 1", done_cnt); end
        run_flush(rdy, done_cnt, done_cyc);
        checks++; if (n_txn !== 0) begin errors++; $display("FAIL t5_clean_writes got %0d want 0", n_txn); end
        checks++; if (done_cnt !== 1 || done_cyc < 1 || done_cyc > 65) begin errors++; $display("FAIL t5_clean_done got pulses=%0d cyc=%0d want pulses=1 cyc<=65", done_cnt, done_cyc); end
        run_req(1'b0, 10'h055, 32'h0, 4'h0, 0, 32'h0);
        checks++; if (n_txn !== 0 || resp_lat !== 1 || resp_data !== 32'h00001121) begin errors++; $display("FAIL t5_line_kept got n=%0d lat=%0d d=%h want n=0 lat=1 d=00001121", n_txn, resp_lat, resp_data); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; address = 10'h075;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            if (mem_req_valid) seen = 1'b1;
        end
        checks++; if (!seen || mem_req_write !== 1'b0 || mem_address !== 10'h075) begin errors++; $display("FAIL t6_refill_issue got seen=%b w=%b a=%h want seen=1 w=0 a=075", seen, mem_req_write, mem_address); end
        reset = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL t6_abort got %b want 0", mem_req_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL t6_ready_in_reset got %b want 1", req_ready); end
        @(negedge clk);
        reset = 1'b1;
        run_req(1'b0, 10'h055, 32'h0, 4'h0, 0, 32'hA5A5A5A5);
        checks++; if (n_txn !== 1 || log_w[0] !== 1'b0 || log_a[0] !== 10'h055) begin errors++; $display("FAIL t6_post_reset_miss got n=%0d w=%b a=%h want n=1 w=0 a=055", n_txn, log_w[0], log_a[0]); end
        checks++; if (resp_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL t6_post_reset_data got %h want A5A5A5A5", resp_data); end
    endtask

    initial begin
        test_reset();
        test_refill_hit();
        test_second_way();
        test_store_hit();
        test_writeback();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
